// File: rtl/pipe_dest_tracker.sv
// pipe_dest_tracker: tracks destination register and write-enable per pipeline
// stage (EX/MEM/WB) for the forwarding unit, and detects load-use hazards that
// need a one-cycle decode stall with a bubble injected into EX.
module pipe_dest_tracker #(
    parameter int unsigned AW       = 4,
    parameter int unsigned ZERO_REG = 15,
    parameter int unsigned CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_addr_a,
    input  logic [AW-1:0] id_addr_b,
    input  logic          id_use_a,
    input  logic          id_use_b,
    input  logic [AW-1:0] id_dest,
    input  logic          id_regwr,
    input  logic          id_memrd,
    input  logic          flush,
    output logic [AW-1:0] dest_ex,
    output logic [AW-1:0] dest_mem,
    output logic [AW-1:0] dest_wb,
    output logic          regwr_ex,
    output logic          regwr_mem,
    output logic          regwr_wb,
    output logic          memrd_ex,
    output logic          stall,
    output logic [CW-1:0] stall_cnt
);

    // EX needs the load flag for hazard detection; MEM/WB only feed forwarding
    typedef struct packed {
        logic [AW-1:0] dest;
        logic          regwr;
        logic          memrd;
    } ex_rec_t;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic          regwr;
    } wr_rec_t;

    ex_rec_t       ex_q;
    wr_rec_t       mem_q;
    wr_rec_t       wb_q;
    ex_rec_t       dec_rec;
    ex_rec_t       ex_next;
    logic          dec_regwr;
    logic          hit_a;
    logic          hit_b;
    logic [CW-1:0] cnt_q;

    // Qualify decode write-enable: zero register writes are never tracked
    assign dec_regwr = id_valid & id_regwr & (id_dest != AW'(ZERO_REG));

    // Load-use detect against the load currently in EX; flush overrides
    assign hit_a = id_use_a & (id_addr_a == ex_q.dest);
    assign hit_b = id_use_b & (id_addr_b == ex_q.dest);
    assign stall = id_valid & ~flush & ex_q.memrd & ex_q.regwr & (hit_a | hit_b);

    // Decode record, replaced by a bubble on stall, flush or empty decode slot
    always_comb begin
        dec_rec       = '0;
        dec_rec.dest  = id_dest;
        dec_rec.regwr = dec_regwr;
        dec_rec.memrd = id_memrd;
        ex_next       = dec_rec;
        if (stall || flush || !id_valid) begin
            ex_next = '0;
        end
    end

    // Stage records advance every cycle; no downstream back-pressure
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q        <= ex_next;
            mem_q.dest  <= ex_q.dest;
            mem_q.regwr <= ex_q.regwr;
            wb_q        <= mem_q;
        end
    end

    // Saturating stall-cycle counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign dest_ex   = ex_q.dest;
    assign regwr_ex  = ex_q.regwr;
    assign memrd_ex  = ex_q.memrd;
    assign dest_mem  = mem_q.dest;
    assign regwr_mem = mem_q.regwr;
    assign dest_wb   = wb_q.dest;
    assign regwr_wb  = wb_q.regwr;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Testbench for pipe_dest_tracker: vector table with hand-written stall
// expectations, plus a queue of expected stage records checked per cycle.
module tb_pipe_dest_tracker;

    localparam int unsigned AW = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_addr_a, id_addr_b, id_dest;
    logic          id_use_a, id_use_b, id_regwr, id_memrd, flush;
    logic [AW-1:0] dest_ex, dest_mem, dest_wb;
    logic          regwr_ex, regwr_mem, regwr_wb, memrd_ex, stall;
    logic [CW-1:0] stall_cnt;

    pipe_dest_tracker #(.AW(AW), .ZERO_REG(15), .CW(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_addr_a(id_addr_a), .id_addr_b(id_addr_b),
        .id_use_a(id_use_a), .id_use_b(id_use_b),
        .id_dest(id_dest), .id_regwr(id_regwr), .id_memrd(id_memrd),
        .flush(flush),
        .dest_ex(dest_ex), .dest_mem(dest_mem), .dest_wb(dest_wb),
        .regwr_ex(regwr_ex), .regwr_mem(regwr_mem), .regwr_wb(regwr_wb),
        .memrd_ex(memrd_ex), .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [AW-1:0] a;
        logic          ua;
        logic [AW-1:0] b;
        logic          ub;
        logic [AW-1:0] dest;
        logic          regwr;
        logic          memrd;
        logic          flush;
        logic          exp_stall;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic          regwr;
        logic          memrd;
        logic          bub;
    } rec_t;

    rec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;
    int   step    = 0;
    vec_t tbl[21];

    function automatic vec_t mk(input int valid, input int a, input int ua,
                                input int b, input int ub, input int dest,
                                input int regwr, input int memrd,
                                input int fl, input int st);
        vec_t v;
        v.valid = 1'(valid); v.a = 4'(a); v.ua = 1'(ua);
        v.b = 4'(b); v.ub = 1'(ub); v.dest = 4'(dest);
        v.regwr = 1'(regwr); v.memrd = 1'(memrd);
        v.flush = 1'(fl); v.exp_stall = 1'(st);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
        end
    endtask

    task automatic sb_reset();
        rec_t z;
        z = '{dest: '0, regwr: 1'b0, memrd: 1'b0, bub: 1'b1};
        sb.delete();
        repeat (3) sb.push_back(z);
        exp_cnt = 0;
    endtask

    // Compare stage outputs against the three newest expected records
    task automatic check_pipe();
        rec_t e_ex, e_mem, e_wb;
        int n;
        n = sb.size();
        e_ex  = sb[n-1];
        e_mem = sb[n-2];
        e_wb  = sb[n-3];
        chk("regwr_ex", int'(regwr_ex), int'(e_ex.regwr));
        chk("memrd_ex", int'(memrd_ex), int'(e_ex.memrd));
        if (e_ex.regwr || e_ex.bub) chk("dest_ex", int'(dest_ex), int'(e_ex.dest));
        chk("regwr_mem", int'(regwr_mem), int'(e_mem.regwr));
        if (e_mem.regwr || e_mem.bub) chk("dest_mem", int'(dest_mem), int'(e_mem.dest));
        chk("regwr_wb", int'(regwr_wb), int'(e_wb.regwr));
        if (e_wb.regwr || e_wb.bub) chk("dest_wb", int'(dest_wb), int'(e_wb.dest));
        chk("stall_cnt", int'(stall_cnt), exp_cnt);
        while (sb.size() > 3) void'(sb.pop_front());
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.valid; id_addr_a = v.a; id_use_a = v.ua;
        id_addr_b = v.b; id_use_b = v.ub; id_dest = v.dest;
        id_regwr = v.regwr; id_memrd = v.memrd; flush = v.flush;
    endtask

    // One cycle: check combinational stall, push expected EX record, clock, check
    task automatic apply(input vec_t v);
        rec_t r;
        drive(v);
        #1;
        chk("stall", int'(stall), int'(v.exp_stall));
        if (v.exp_stall || v.flush || !v.valid) begin
            r = '{dest: '0, regwr: 1'b0, memrd: 1'b0, bub: 1'b1};
        end else begin
            r.dest  = v.dest;
            r.regwr = v.regwr && (v.dest != 4'd15);
            r.memrd = v.memrd;
            r.bub   = 1'b0;
        end
        sb.push_back(r);
        if (v.exp_stall && exp_cnt != 15) exp_cnt++;
        @(posedge clk);
        #1;
        check_pipe();
        step++;
    endtask

    initial begin
        //            vld a ua b ub dst wr rd fl stall
        tbl[0]  = mk(1, 0, 0, 0, 0,  5, 1, 1, 0, 0); // ld r5
        tbl[1]  = mk(1, 5, 1, 0, 0,  6, 1, 0, 0, 1); // uses r5 -> stall
        tbl[2]  = mk(1, 5, 1, 0, 0,  6, 1, 0, 0, 0); // held, load now in MEM
        tbl[3]  = mk(1, 0, 0, 0, 0,  5, 1, 1, 0, 0); // ld r5
        tbl[4]  = mk(1, 3, 1, 5, 0,  8, 1, 0, 0, 0); // unused Rm match ignored
        tbl[5]  = mk(1, 0, 0, 0, 0, 15, 1, 1, 0, 0); // ld r15
        tbl[6]  = mk(1, 15, 1, 0, 0, 9, 1, 0, 0, 0); // reads r15: no stall
        tbl[7]  = mk(1, 0, 0, 0, 0,  7, 1, 0, 0, 0); // alu r7
        tbl[8]  = mk(0, 7, 1, 7, 1,  0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 0,  1, 1, 1, 0, 0); // ld r1
        tbl[12] = mk(1, 1, 1, 0, 0,  2, 1, 1, 0, 1); // ld r2 uses r1
        tbl[13] = mk(1, 1, 1, 0, 0,  2, 1, 1, 0, 0); // held
        tbl[14] = mk(1, 0, 0, 2, 1,  3, 1, 0, 0, 1); // uses r2 via Rm
        tbl[15] = mk(1, 0, 0, 2, 1,  3, 1, 0, 0, 0); // held
        tbl[16] = mk(1, 0, 0, 0, 0,  4, 1, 1, 0, 0); // ld r4
        tbl[17] = mk(1, 4, 1, 0, 0, 10, 1, 0, 1, 0); // hazard + flush
        tbl[18] = mk(1, 4, 1, 0, 0, 10, 1, 0, 0, 0); // EX is bubble now
        tbl[19] = mk(1, 0, 0, 0, 0,  6, 1, 1, 0, 0); // ld r6
        tbl[20] = mk(0, 6, 1, 0, 0,  0, 0, 0, 0, 0); // invalid decode

        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb_reset();
        #1;
        chk("reset_stall", int'(stall), 0);
        check_pipe();

        for (int i = 0; i < 21; i++) apply(tbl[i]);

        // Saturation: 20 load-use stalls with CW=4
        for (int k = 0; k < 20; k++) begin
            apply(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0));
            apply(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 1));
            apply(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0));
        end
        chk("sat_cnt", int'(stall_cnt), 15);

        // Reset asserted mid-stall clears counter and all stages
        apply(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0));
        drive(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 1));
        #1;
        chk("pre_reset_stall", int'(stall), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_cnt", int'(stall_cnt), 0);
        chk("rst_regwr_ex", int'(regwr_ex), 0);
        chk("rst_regwr_mem", int'(regwr_mem), 0);
        chk("rst_regwr_wb", int'(regwr_wb), 0);
        chk("rst_stall", int'(stall), 0);
        reset = 1'b0;
        sb_reset();
        apply(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_dest_tracker.md
# pipe_dest_tracker

Producer side of the operand-forwarding interface. The block records, for each pipeline stage, the destination register and the write-enable of the instruction in that stage. It drives the EX/MEM destination and write-enable signals that the forwarding unit consumes, plus a WB copy. It detects load-use hazards that forwarding cannot cover, then stalls decode and injects a one-cycle bubble into EX. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and is fed from the decode stage.

## Interface
Parameters:
- AW, 4, register address width
- ZERO_REG, 15, hard-wired zero register; writes to it are never tracked
- CW, 16, width of the stall performance counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode stage holds a valid instruction
- id_addr_a, id_addr_b  in  AW  source registers (Rn, Rm) of the decode instruction
- id_use_a, id_use_b  in  1  the decode instruction actually reads that source
- id_dest  in  AW  destination register (Rd) of the decode instruction
- id_regwr  in  1  decode instruction writes the register file
- id_memrd  in  1  decode instruction is a load
- flush  in  1  taken branch resolved in EX; squash the decode instruction
- dest_ex, dest_mem, dest_wb  out  AW  Rd of the instructions in EX / MEM / WB
- regwr_ex, regwr_mem, regwr_wb  out  1  effective write enables per stage
- memrd_ex  out  1  EX instruction is a load
- stall  out  1  hold PC and IF/ID; bubble into EX this cycle
- stall_cnt  out  CW  saturating count of stall cycles

## Operation
- Stage records {dest, regwr, memrd} exist for EX, MEM and WB.
- The decode record is qualified with this rule: effective regwr = id_valid & id_regwr & (id_dest != ZERO_REG). A record with effective regwr = 0 never causes forwarding or a stall.
- Advance on every clock edge that is not a reset edge:
  - EX <= decode record, or a bubble {0,0,0} if stall, flush or !id_valid.
  - MEM <= EX.
  - WB <= MEM.
- MEM and WB always advance. The block has no back-pressure from downstream.
- Load-use detect (combinational, from registered EX state and decode inputs):
  - stall = id_valid & !flush & memrd_ex & regwr_ex & ((id_use_a & id_addr_a == dest_ex) | (id_use_b & id_addr_b == dest_ex)).
- Stall duration is exactly one cycle per hazard. The bubble clears memrd_ex on the next cycle. The load then sits in MEM and the forwarding unit supplies its data from MEM.
- Back-to-back loads each feeding the next instruction each stall once. The stalls never merge into a two-cycle stall.
- flush has priority over stall. When both conditions hold, stall = 0 and EX receives a bubble.
- A bubble has dest = 0 and regwr = 0. dest_* output values are don't-care whenever the matching regwr_* = 0, but must still be 0 after reset and for bubbles.
- stall_cnt increments by 1 on each clock edge where stall = 1. It saturates at 2^CW-1 and never wraps. It is cleared only by reset.

## Timing
- Reset (synchronous, sampled at the clk edge): all stage records become 0 and stall_cnt becomes 0. Consequently stall = 0 in the first cycle after reset.
- If reset is asserted mid-stall, the stall drops on the next cycle and the counter clears. Reset wins over increment.
- All dest_*, regwr_*, memrd_ex and stall_cnt outputs are registered.
- stall is combinational from the registered EX record plus the current-cycle id_* and flush inputs. No registered-output path adds latency to it.
- Latency: a decode record appears on *_ex 1 cycle after acceptance, on *_mem after 2 cycles, and on *_wb after 3 cycles.
- During a stall, the decode inputs are held by the upstream pipeline. The block does not latch them.

## Test plan
- After reset, a load with Rd=5 is in EX; decode reads Rn=5 with use_a=1. Required: stall=1 for exactly that cycle. Next cycle: regwr_ex=0, regwr_mem=1, dest_mem=5, stall=0. stall_cnt=1.
- Load with Rd=5 in EX; decode has Rm=5 with use_b=0, and Rn=3. Required: stall=0. The non-used-operand match is ignored.
- Load with Rd=ZERO_REG(15) in EX; decode reads Rn=15. Required: stall=0, regwr_ex=0.
- ALU write of Rd=7 (no load) accepted in cycle 0. Required: dest_ex=7 / regwr_ex=1 in cycle 1; the same on _mem in cycle 2 and on _wb in cycle 3; stall stays 0 throughout.
- Load-use hazard present with flush=1 in the same cycle. Required: stall=0, the EX record in the next cycle is a bubble, and stall_cnt is unchanged.
- With CW=4, force 20 load-use stalls. Required: stall_cnt reads 15 and holds there. Asserting reset clears stall_cnt to 0 and regwr_ex/mem/wb to 0 on the next edge.
